// File: rtl/montgomery_pkg.sv
// montgomery_pkg: shared FSM state type and width helpers for the radix-2^RB Montgomery multiplier
package montgomery_pkg;
  typedef enum logic [1:0] {IDLE, MUL, SUB, DONE} state_t;
  localparam int DEF_N = 512;
  localparam int DEF_RB = 4;
  localparam int DEF_ITER = DEF_N / DEF_RB;
  function automatic int cnt_w(input int iter);
    return iter > 1 ? $clog2(iter) : 1;
  endfunction
  function automatic int acc_w(input int n, input int rb);
    return n + rb + 2;
  endfunction
endpackage

// File: rtl/montgomery_radix_mul_step.sv
// mont_digit_step: one radix-2^RB Montgomery iteration, C' = (C + a_i*B + q*M) >> RB
module mont_digit_step
  import montgomery_pkg::*;
#(
  parameter int N = 512,
  parameter int RB = 4
) (
  input  logic [N+1:0]  c,
  input  logic [RB-1:0] a_i,
  input  logic [N-1:0]  b,
  input  logic [N-1:0]  m,
  input  logic [RB-1:0] m_prime,
  output logic [N+1:0]  c_next,
  output logic [RB-1:0] q
);
  localparam int W = acc_w(N, RB);
  logic [W-1:0] t, s;
  logic [2*RB-1:0] qp;
  always_comb begin
    t = W'(c) + W'(a_i) * W'(b);
    qp = {{RB{1'b0}}, t[RB-1:0]} * {{RB{1'b0}}, m_prime};
    q = qp[RB-1:0];
    s = t + W'(q) * W'(m);
    c_next = (N+2)'(s >> RB);
  end
endmodule

// File: rtl/montgomery_radix_mul.sv
// montgomery_radix_mul: iterative A*B*2^-N mod M, RB bits of A per cycle; MONT_FINAL_SUB_EN adds the final reducing subtract
module montgomery_radix_mul
  import montgomery_pkg::*;
#(
  parameter int N = 512,
  parameter int RB = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic [N-1:0]  in_m,
  input  logic [RB-1:0] in_m_prime,
  output logic          busy,
  output logic [N-1:0]  result,
  output logic          done
);
  localparam int ITER = N / RB;
  localparam int CW = cnt_w(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);
  state_t state;
  logic [N-1:0] a_sh, b_r, m_r;
  logic [RB-1:0] mp_r, q;
  logic [N+1:0] c, c_next;
  logic [CW-1:0] cnt;
`ifdef MONT_FINAL_SUB_EN
  logic [N+1:0] d;
  assign d = c - {2'b00, m_r};
`endif
  mont_digit_step #(.N(N), .RB(RB)) u_step (
    .c(c), .a_i(a_sh[RB-1:0]), .b(b_r), .m(m_r), .m_prime(mp_r), .c_next(c_next), .q(q)
  );
  assign busy = state == MUL || state == SUB;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      result <= '0;
      c <= '0;
      cnt <= '0;
      a_sh <= '0;
      b_r <= '0;
      m_r <= '0;
      mp_r <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh <= in_a;
          b_r <= in_b;
          m_r <= in_m;
          mp_r <= in_m_prime;
          c <= '0;
          cnt <= '0;
          state <= MUL;
        end
        MUL: begin
          c <= c_next;
          a_sh <= a_sh >> RB;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
`ifdef MONT_FINAL_SUB_EN
            state <= SUB;
`else
            state <= DONE;
            result <= c_next[N-1:0];
`endif
          end
        end
        SUB: begin
`ifdef MONT_FINAL_SUB_EN
          result <= d[N+1] ? c[N-1:0] : d[N-1:0];
`endif
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // q must cancel the low digit of t so the shift loses nothing
  a_q_cancels: assert property (@(posedge clk) disable iff (reset)
    state == MUL |-> RB'(c[RB-1:0] + a_sh[RB-1:0] * b_r[RB-1:0] + q * m_r[RB-1:0]) == '0);
endmodule
